// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Frame-timing stage of the 7-segment animation engine. It holds the active
// animation index, which feeds the frame-count lookup. It takes the returned
// frame count (`limit`) and steps `frame` from 0 to L-1 at a programmable
// rate, wrapping back to 0 at the end. `animation` and `frame` address the
// segment-pattern ROM downstream.
//
// Optional feature (compile-time macro FRAME_SEQ_AUTO_CYCLE_EN):
//   When this macro is defined, a loop counter counts wraps while `auto_en`
//   is high. After LOOPS completed loops, `animation` advances by one
//   (mod 64). When the macro is undefined, `auto_en` is ignored and
//   `animation` changes only through `load` or reset.
//
// Parameters:
//   PRESCALE_W  prescaler width (8..24); step period T = 2^(PRESCALE_W-2*speed)
//   LOOPS       completed loops before auto-advance (1..15)
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   ena         global enable; all state holds while low
//   anim_sel    requested animation index, taken while `load` is high
//   load        loads anim_sel and restarts frame, prescaler and loop count
//   speed       tick-rate select
//   pause       freezes the prescaler and therefore frame stepping
//   auto_en     auto-advance request (used only with FRAME_SEQ_AUTO_CYCLE_EN)
//   limit       frame count from the lookup; 0 means 32 frames
//   animation   registered active animation index
//   frame       registered current frame index
//   frame_tick  one-cycle pulse on every frame step, including a wrap
//   wrap        one-cycle pulse when a step returns frame to 0
// -----------------------------------------------------------------------------
module frame_sequencer #(
    parameter int PRESCALE_W = 20,
    parameter int LOOPS      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [5:0] anim_sel,
    input  logic       load,
    input  logic [1:0] speed,
    input  logic       pause,
    input  logic       auto_en,
    input  logic [4:0] limit,
    output logic [5:0] animation,
    output logic [4:0] frame,
    output logic       frame_tick,
    output logic       wrap
);

    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] pre_cnt;
    logic [PRESCALE_W-1:0] pre_top;
    logic [5:0]            eff_limit;
    logic                  tick;
    logic                  at_last;
    logic                  over_limit;

    // T-1 is all ones shifted right by 2*speed.
    assign pre_top = {PRESCALE_W{1'b1}} >> {speed, 1'b0};

    // A speed change can leave the count above the new terminal value.
    // The >= compare then fires on the next cycle instead of running on
    // until the counter wraps.
    assign tick = ena && !pause && (pre_cnt >= pre_top);

    // A limit of 0 encodes 32 frames, so the effective limit needs 6 bits.
    assign eff_limit  = (limit == 5'd0) ? 6'd32 : {1'b0, limit};
    assign at_last    = ({1'b0, frame} >= (eff_limit - 6'd1));
    assign over_limit = ({1'b0, frame} >= eff_limit);

`ifdef FRAME_SEQ_AUTO_CYCLE_EN
    localparam logic [3:0] LOOPS_TC = 4'(LOOPS);
    logic [3:0] loop_cnt;
`else
    logic unused_auto;
    assign unused_auto = auto_en ^ (LOOPS == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt    <= '0;
            animation  <= '0;
            frame      <= '0;
            frame_tick <= 1'b0;
            wrap       <= 1'b0;
`ifdef FRAME_SEQ_AUTO_CYCLE_EN
            loop_cnt   <= '0;
`endif
        end else begin
            frame_tick <= 1'b0;
            wrap       <= 1'b0;
            if (ena) begin
                if (load) begin
                    animation <= anim_sel;
                    frame     <= '0;
                    pre_cnt   <= '0;
`ifdef FRAME_SEQ_AUTO_CYCLE_EN
                    loop_cnt  <= '0;
`endif
                end else begin
                    if (!pause) begin
                        pre_cnt <= tick ? '0 : pre_cnt + PRE_ONE;
                    end

                    if (tick) begin
                        frame_tick <= 1'b1;
                        if (at_last) begin
                            frame <= '0;
                            wrap  <= 1'b1;
`ifdef FRAME_SEQ_AUTO_CYCLE_EN
                            if (auto_en) begin
                                if ((loop_cnt + 4'd1) == LOOPS_TC) begin
                                    animation <= animation + 6'd1;
                                    loop_cnt  <= '0;
                                end else begin
                                    loop_cnt <= loop_cnt + 4'd1;
                                end
                            end
`endif
                        end else begin
                            frame <= frame + 5'd1;
                        end
                    end else if (over_limit) begin
                        // limit dropped under the current frame: snap back
                        // silently
                        frame <= '0;
                    end

`ifdef FRAME_SEQ_AUTO_CYCLE_EN
                    if (!auto_en) begin
                        loop_cnt <= '0;
                    end
`endif
                end
            end
        end
    end

endmodule
